// File: rtl/alarm_sequencer_pkg.sv
// Shared types and default parameters for the vault alarm sequencer.
// Holds the 2-bit state encoding shown on the LCD debug display.
package alarm_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUALIFY  = 2'd1,
    ALARM    = 2'd2,
    SILENCED = 2'd3
  } state_t;

  localparam int ARM_DELAY_DEF  = 4;
  localparam int BLINK_HALF_DEF = 2;
  localparam int CNT_BITS_DEF   = 4;

  function automatic logic isAlarm(state_t s);
    return s == ALARM;
  endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Groups the alarm inputs and indicator outputs of the sequencer.
// The slave side is the sequencer; the master side is its environment.
interface alarm_sequencer_if
  import alarm_sequencer_pkg::*;
#(
  parameter int CNT_BITS = CNT_BITS_DEF
);

  logic                alarm_in;
  logic                ack;
  logic                siren;
  logic                blink;
  logic [1:0]          state;
  logic [CNT_BITS-1:0] trip_count;

  modport slave (
    input  alarm_in,
    input  ack,
    output siren,
    output blink,
    output state,
    output trip_count
  );

  modport master (
    output alarm_in,
    output ack,
    input  siren,
    input  blink,
    input  state,
    input  trip_count
  );

endinterface

// File: rtl/alarm_sequencer_blink_div.sv
// Blink phase generator: high for HALF cycles after enable, then low for HALF,
// repeating; the phase restarts whenever en drops.
module blink_div
  import alarm_sequencer_pkg::*;
#(
  parameter int HALF = BLINK_HALF_DEF
) (
  input  logic clk_2,
  input  logic reset,
  input  logic en,
  output logic out
);

  localparam logic [7:0] HALF_M1 = 8'(HALF - 1);

  logic [7:0] cnt_q;
  logic       phase_q;

  always_ff @(posedge clk_2) begin
    if (reset || !en) begin
      cnt_q   <= 8'd0;
      phase_q <= 1'b0;
    end else if (cnt_q == HALF_M1) begin
      cnt_q   <= 8'd0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // en comes from the state register, so this gate adds no input-to-output path
  assign out = en & ~phase_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Vault alarm sequencer: qualifies a raw alarm over ARM_DELAY samples, latches
// it until acknowledged, flashes an indicator and counts trips (saturating).
module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter int ARM_DELAY  = ARM_DELAY_DEF,
  parameter int BLINK_HALF = BLINK_HALF_DEF,
  parameter int CNT_BITS   = CNT_BITS_DEF
) (
  input  logic               clk_2,
  input  logic               reset,
  alarm_sequencer_if.slave   bus
);

  localparam logic [7:0]          ARM_D    = 8'(ARM_DELAY);
  localparam logic [CNT_BITS-1:0] TRIP_MAX = {CNT_BITS{1'b1}};

  state_t              state_q;
  logic [7:0]          qualCnt_q;
  logic [CNT_BITS-1:0] tripCount_q;
  logic [CNT_BITS-1:0] tripCount_d;
  logic                siren_q;
  logic                blinkOut;

  always_comb begin
    tripCount_d = tripCount_q;
    if (tripCount_q != TRIP_MAX) begin
      tripCount_d = tripCount_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q     <= IDLE;
      qualCnt_q   <= 8'd0;
      tripCount_q <= '0;
      siren_q     <= 1'b0;
    end else begin
      siren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.alarm_in) begin
            if (ARM_D == 8'd1) begin
              state_q     <= ALARM;
              siren_q     <= 1'b1;
              tripCount_q <= tripCount_d;
            end else begin
              state_q   <= QUALIFY;
              qualCnt_q <= 8'd1;
            end
          end
        end
        QUALIFY: begin
          if (!bus.alarm_in) begin
            state_q   <= IDLE;
            qualCnt_q <= 8'd0;
          end else if (qualCnt_q + 8'd1 == ARM_D) begin
            state_q     <= ALARM;
            qualCnt_q   <= 8'd0;
            siren_q     <= 1'b1;
            tripCount_q <= tripCount_d;
          end else begin
            qualCnt_q <= qualCnt_q + 8'd1;
          end
        end
        ALARM: begin
          // Latched until a manager acknowledges; a still-active alarm is only silenced
          if (bus.ack) begin
            state_q <= bus.alarm_in ? SILENCED : IDLE;
          end else begin
            siren_q <= 1'b1;
          end
        end
        SILENCED: begin
          if (!bus.alarm_in) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  blink_div #(
    .HALF(BLINK_HALF)
  ) u_blink (
    .clk_2(clk_2),
    .reset(reset),
    .en   (isAlarm(state_q)),
    .out  (blinkOut)
  );

  assign bus.siren      = siren_q;
  assign bus.blink      = blinkOut;
  assign bus.state      = state_q;
  assign bus.trip_count = tripCount_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer with ARM_DELAY=4, BLINK_HALF=2, CNT_BITS=4.
// Stimulus pushes hand-computed post-edge expectations; a monitor pops and compares.
module tb_alarm_sequencer;

  typedef struct {
    logic [1:0] st;
    logic       sir;
    logic       blk;
    logic [3:0] trip;
    string      name;
  } exp_t;

  logic clk_2 = 1'b0;
  logic reset = 1'b0;

  int   testsRun = 0;
  int   failures = 0;
  exp_t scb[$];
  exp_t cur;

  alarm_sequencer_if #(.CNT_BITS(4)) bus ();

  alarm_sequencer #(
    .ARM_DELAY (4),
    .BLINK_HALF(2),
    .CNT_BITS  (4)
  ) dut (
    .clk_2(clk_2),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk_2 = ~clk_2;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic a, input logic k, input logic r,
                               input logic [1:0] st, input logic sir,
                               input logic blk, input logic [3:0] trip,
                               input string name);
    exp_t e;
    @(negedge clk_2);
    bus.alarm_in = a;
    bus.ack      = k;
    reset        = r;
    e.st   = st;
    e.sir  = sir;
    e.blk  = blk;
    e.trip = trip;
    e.name = name;
    scb.push_back(e);
  endtask

  // Three QUALIFY edges then the ALARM entry edge, with alarm_in held high
  task automatic tripOnce(input logic [3:0] prevTrip, input logic [3:0] newTrip,
                          input string name);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 2'd1, 0, 0, prevTrip, name);
    applyStimulus(1, 0, 0, 2'd2, 1, 1, newTrip, name);
  endtask

  task automatic checkOutput(input exp_t e);
    testsRun++;
    if (bus.state !== e.st) begin
      failures++;
      $display("[TB] FAIL %s.state got %0d want %0d", e.name, bus.state, e.st);
    end
    testsRun++;
    if (bus.siren !== e.sir) begin
      failures++;
      $display("[TB] FAIL %s.siren got %0b want %0b", e.name, bus.siren, e.sir);
    end
    testsRun++;
    if (bus.blink !== e.blk) begin
      failures++;
      $display("[TB] FAIL %s.blink got %0b want %0b", e.name, bus.blink, e.blk);
    end
    testsRun++;
    if (bus.trip_count !== e.trip) begin
      failures++;
      $display("[TB] FAIL %s.trip got %0d want %0d", e.name, bus.trip_count, e.trip);
    end
  endtask

  always @(posedge clk_2) begin
    #1;
    if (scb.size() != 0) begin
      cur = scb.pop_front();
      checkOutput(cur);
    end
  end

  initial begin
    bus.alarm_in = 1'b0;
    bus.ack      = 1'b0;

    applyStimulus(1, 1, 1, 2'd0, 0, 0, 4'd0, "reset");
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 4'd0, "idle");

    // Scenario 1: three highs then low drops back to IDLE
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 2'd1, 0, 0, 4'd0, "s1Qual");
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 4'd0, "s1Drop");

    // Scenario 2: held high trips on the 4th edge, blink 1,1,0,0,1,1
    tripOnce(4'd0, 4'd1, "s2Trip");
    applyStimulus(1, 0, 0, 2'd2, 1, 1, 4'd1, "s2Blink1");
    applyStimulus(1, 0, 0, 2'd2, 1, 0, 4'd1, "s2Blink2");
    applyStimulus(1, 0, 0, 2'd2, 1, 0, 4'd1, "s2Blink3");
    applyStimulus(1, 0, 0, 2'd2, 1, 1, 4'd1, "s2Blink4");
    applyStimulus(1, 0, 0, 2'd2, 1, 1, 4'd1, "s2Blink5");

    // Scenario 3: latched with alarm low, then acknowledged
    applyStimulus(0, 0, 0, 2'd2, 1, 0, 4'd1, "s3Latch");
    applyStimulus(0, 0, 0, 2'd2, 1, 0, 4'd1, "s3Latch");
    applyStimulus(0, 0, 0, 2'd2, 1, 1, 4'd1, "s3Latch");
    applyStimulus(0, 0, 0, 2'd2, 1, 1, 4'd1, "s3Latch");
    applyStimulus(0, 0, 0, 2'd2, 1, 0, 4'd1, "s3Latch");
    applyStimulus(0, 1, 0, 2'd0, 0, 0, 4'd1, "s3Ack");
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 4'd1, "s3Idle");

    // Scenario 4: silence, exit, requalify with ack held (ignored)
    applyStimulus(0, 0, 1, 2'd0, 0, 0, 4'd0, "s4Reset");
    tripOnce(4'd0, 4'd1, "s4Trip");
    applyStimulus(1, 1, 0, 2'd3, 0, 0, 4'd1, "s4Silence");
    applyStimulus(1, 1, 0, 2'd3, 0, 0, 4'd1, "s4SilAck");
    applyStimulus(0, 1, 0, 2'd0, 0, 0, 4'd1, "s4SilExit");
    applyStimulus(0, 1, 0, 2'd0, 0, 0, 4'd1, "s4IdleAck");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 2'd1, 0, 0, 4'd1, "s4QualAck");
    applyStimulus(1, 0, 0, 2'd2, 1, 1, 4'd2, "s4Retrip");

    // Scenario 5: 16 trips, count saturates at 15
    applyStimulus(0, 0, 1, 2'd0, 0, 0, 4'd0, "s5Reset");
    for (int n = 1; n <= 16; n++) begin
      logic [3:0] prevT;
      logic [3:0] newT;
      prevT = (n - 1 > 15) ? 4'd15 : 4'(n - 1);
      newT  = (n > 15) ? 4'd15 : 4'(n);
      tripOnce(prevT, newT, "s5Trip");
      applyStimulus(0, 1, 0, 2'd0, 0, 0, newT, "s5Ack");
    end

    // Scenario 6: reset mid-ALARM and mid-QUALIFY discards progress
    tripOnce(4'd15, 4'd15, "s6Trip");
    applyStimulus(1, 0, 1, 2'd0, 0, 0, 4'd0, "s6RstAlarm");
    tripOnce(4'd0, 4'd1, "s6Requal");
    applyStimulus(0, 1, 0, 2'd0, 0, 0, 4'd1, "s6Ack");
    applyStimulus(1, 0, 0, 2'd1, 0, 0, 4'd1, "s6Qual");
    applyStimulus(1, 0, 0, 2'd1, 0, 0, 4'd1, "s6Qual");
    applyStimulus(1, 0, 1, 2'd0, 0, 0, 4'd0, "s6RstQual");
    tripOnce(4'd0, 4'd1, "s6Requal2");

    repeat (3) @(negedge clk_2);
    testsRun++;
    if (scb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got %0d pending want 0", scb.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter ARM_DELAY, default 4: consecutive sampled-high cycles of alarm_in needed to trip; legal range 1..255.
REQ-002 Parameter BLINK_HALF, default 2: cycles per blink half-period; legal range 1..255.
REQ-003 Parameter CNT_BITS, default 4: width of trip_count.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk_2  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 alarm_in  input  1  raw alarm condition from the combinational vault-alarm decode.
REQ-008 ack  input  1  manager acknowledge, level-sampled each edge.
REQ-009 siren  output  1  latched alarm indication, drives LED.
REQ-010 blink  output  1  flashing indicator, drives SEG.
REQ-011 state  output  2  current FSM state encoding, for the LCD debug display.
REQ-012 trip_count  output  CNT_BITS  number of trips since reset, saturating.

Function
REQ-013 The FSM shall have states IDLE=0, QUALIFY=1, ALARM=2, SILENCED=3.
REQ-014 IDLE: alarm_in=1 -> QUALIFY with qualify counter=1; otherwise stay.
REQ-015 QUALIFY: alarm_in=0 -> IDLE, counter cleared; alarm_in=1 -> counter increments.
REQ-016 QUALIFY -> ALARM on the edge where alarm_in has been sampled high on ARM_DELAY consecutive edges, counting the edge that left IDLE.
REQ-017 With ARM_DELAY=1, IDLE shall go directly to ALARM on the first high sample.
REQ-018 On entry to ALARM, trip_count shall increment by 1 and saturate at 2^CNT_BITS-1, with no wrap.
REQ-019 ALARM is latched: alarm_in=0 without ack keeps the FSM in ALARM.
REQ-020 ALARM with ack=1 and alarm_in=0 -> IDLE; ALARM with ack=1 and alarm_in=1 -> SILENCED.
REQ-021 SILENCED: alarm_in=0 -> IDLE; ack is ignored.
REQ-022 siren shall be 1 iff state==ALARM, decoded from the state register; no input-to-output combinational path.
REQ-023 blink shall be 0 outside ALARM.
REQ-024 In ALARM, blink shall be 1 for the first BLINK_HALF cycles after entry, then 0 for BLINK_HALF cycles, repeating; the phase counter restarts at every ALARM entry.
REQ-025 ack in IDLE or QUALIFY shall have no effect.

Reset
REQ-026 reset=1 at an edge forces state=IDLE, qualify counter=0, blink phase=0, siren=0, blink=0 and trip_count=0, overriding all other inputs.
REQ-027 Reset applied mid-ALARM or mid-QUALIFY shall discard progress; after release, a full ARM_DELAY qualification is required again.

Structure
REQ-028 A shared package shall hold the state enum (2-bit) and the default values of ARM_DELAY, BLINK_HALF and CNT_BITS.
REQ-029 The blink phase generator shall be a sub-module blink_div with ports clk_2, reset, en and out.
REQ-030 Total RTL shall be 120-400 lines.

Verification (ARM_DELAY=4, BLINK_HALF=2, CNT_BITS=4)
REQ-031 Scenario 1: alarm_in high 3 edges, then low -> state 0,1,1,1,0; siren=0; trip_count=0.
REQ-032 Scenario 2: alarm_in held high -> state=2 after the 4th edge; siren=1; trip_count=1; blink sequence 1,1,0,0,1,1.
REQ-033 Scenario 3: in ALARM, alarm_in->0 for 5 cycles -> siren stays 1; one-cycle ack -> next edge state=0, siren=0, blink=0.
REQ-034 Scenario 4: ack with alarm_in=1 -> state=3, siren=0; then alarm_in=0 -> state=0; requalify 4 cycles -> trip_count=2.
REQ-035 Scenario 5: 16 complete trip/ack cycles -> trip_count=15 after the 15th and 16th trips.
REQ-036 Scenario 6: reset in ALARM with alarm_in=1 -> next edge all outputs 0; after release, state=2 only after 4 more high edges.
